// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: sequencing controller for the xAxB number-guessing game.
// Collects a 4-digit secret, then scores player guesses one digit per cycle.
module guess_game_ctrl #(
  parameter logic [3:0] KEY_ENTER = 4'd15,
  parameter logic [3:0] KEY_CLEAR = 4'd12,
  parameter logic [3:0] KEY_SET   = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       qa_state,
  output logic       show,
  output logic [2:0] r_a,
  output logic [2:0] r_b,
  output logic [3:0] keypadBuf,
  output logic [2:0] digit_cnt,
  output logic [7:0] guess_cnt,
  output logic       win
);

  typedef enum logic [1:0] {S_SET, S_GUESS, S_CMP, S_WIN} state_t;

  state_t     state_q, state_d;
  logic       qa_state_q, qa_state_d;
  logic       show_q, show_d;
  logic [2:0] r_a_q, r_a_d;
  logic [2:0] r_b_q, r_b_d;
  logic [3:0] keypad_buf_q, keypad_buf_d;
  logic [2:0] digit_cnt_q, digit_cnt_d;
  logic [7:0] guess_cnt_q, guess_cnt_d;
  logic       win_q, win_d;
  logic [3:0] buf_q [4];
  logic [3:0] buf_d [4];
  logic [3:0] secret_q [4];
  logic [3:0] secret_d [4];
  logic [1:0] idx_q, idx_d;
  logic [2:0] acc_a_q, acc_a_d;
  logic [2:0] acc_b_q, acc_b_d;

  logic       is_digit;
  logic       dup;
  logic       hit_a;
  logic       hit_b;
  logic [2:0] acc_a_nxt;
  logic [2:0] acc_b_nxt;

  // Digit acceptance test and per-position score contribution of the current compare index.
  always_comb begin
    is_digit = (key_code <= 4'd9);
    dup      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < digit_cnt_q) && (buf_q[i] == key_code)) dup = 1'b1;
    end
    hit_a = (buf_q[idx_q] == secret_q[idx_q]);
    hit_b = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != idx_q) && (secret_q[j] == buf_q[idx_q])) hit_b = 1'b1;
    end
    // A wins over B for the same position: B only counts when the digit is misplaced.
    acc_a_nxt = acc_a_q + {2'b00, hit_a};
    acc_b_nxt = acc_b_q + {2'b00, (~hit_a) & hit_b};
  end

  // Next-state and next-output logic; KEY_SET overrides every state.
  always_comb begin
    state_d      = state_q;
    qa_state_d   = qa_state_q;
    show_d       = show_q;
    r_a_d        = r_a_q;
    r_b_d        = r_b_q;
    keypad_buf_d = keypad_buf_q;
    digit_cnt_d  = digit_cnt_q;
    guess_cnt_d  = guess_cnt_q;
    win_d        = win_q;
    buf_d        = buf_q;
    secret_d     = secret_q;
    idx_d        = idx_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;

    if (key_valid && (key_code == KEY_SET)) begin
      state_d     = S_SET;
      qa_state_d  = 1'b1;
      show_d      = 1'b0;
      win_d       = 1'b0;
      r_a_d       = 3'd0;
      r_b_d       = 3'd0;
      digit_cnt_d = 3'd0;
      guess_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_SET, S_GUESS: begin
          if (key_valid) begin
            if (is_digit) begin
              if ((digit_cnt_q < 3'd4) && !dup) begin
                buf_d[digit_cnt_q[1:0]] = key_code;
                digit_cnt_d             = digit_cnt_q + 3'd1;
                keypad_buf_d            = key_code;
                show_d                  = 1'b0;
              end
            end else if (key_code == KEY_CLEAR) begin
              digit_cnt_d = 3'd0;
            end else if ((key_code == KEY_ENTER) && (digit_cnt_q == 3'd4)) begin
              if (state_q == S_SET) begin
                secret_d    = buf_q;
                digit_cnt_d = 3'd0;
                state_d     = S_GUESS;
                qa_state_d  = 1'b0;
              end else begin
                state_d = S_CMP;
                idx_d   = 2'd0;
                acc_a_d = 3'd0;
                acc_b_d = 3'd0;
              end
            end
          end
        end
        S_CMP: begin
          acc_a_d = acc_a_nxt;
          acc_b_d = acc_b_nxt;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            r_a_d       = acc_a_nxt;
            r_b_d       = acc_b_nxt;
            guess_cnt_d = (guess_cnt_q == 8'hFF) ? guess_cnt_q : guess_cnt_q + 8'd1;
            digit_cnt_d = 3'd0;
            show_d      = 1'b1;
            if (acc_a_nxt == 3'd4) begin
              state_d = S_WIN;
              win_d   = 1'b1;
            end else begin
              state_d = S_GUESS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous reset of all control and storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SET;
      qa_state_q   <= 1'b1;
      show_q       <= 1'b0;
      r_a_q        <= 3'd0;
      r_b_q        <= 3'd0;
      keypad_buf_q <= 4'd0;
      digit_cnt_q  <= 3'd0;
      guess_cnt_q  <= 8'd0;
      win_q        <= 1'b0;
      idx_q        <= 2'd0;
      acc_a_q      <= 3'd0;
      acc_b_q      <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        buf_q[k]    <= 4'd0;
        secret_q[k] <= 4'd0;
      end
    end else begin
      state_q      <= state_d;
      qa_state_q   <= qa_state_d;
      show_q       <= show_d;
      r_a_q        <= r_a_d;
      r_b_q        <= r_b_d;
      keypad_buf_q <= keypad_buf_d;
      digit_cnt_q  <= digit_cnt_d;
      guess_cnt_q  <= guess_cnt_d;
      win_q        <= win_d;
      idx_q        <= idx_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      for (int k = 0; k < 4; k++) begin
        buf_q[k]    <= buf_d[k];
        secret_q[k] <= secret_d[k];
      end
    end
  end

  assign qa_state  = qa_state_q;
  assign show      = show_q;
  assign r_a       = r_a_q;
  assign r_b       = r_b_q;
  assign keypadBuf = keypad_buf_q;
  assign digit_cnt = digit_cnt_q;
  assign guess_cnt = guess_cnt_q;
  assign win       = win_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Testbench for guess_game_ctrl: directed key sequences push expected output
// snapshots into a queue; a monitor pops and compares them against the DUT.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       qa_state;
  logic       show;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic [3:0] keypadBuf;
  logic [2:0] digit_cnt;
  logic [7:0] guess_cnt;
  logic       win;

  guess_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .qa_state  (qa_state),
    .show      (show),
    .r_a       (r_a),
    .r_b       (r_b),
    .keypadBuf (keypadBuf),
    .digit_cnt (digit_cnt),
    .guess_cnt (guess_cnt),
    .win       (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Packed view: qa, show, r_a, r_b, keypadBuf, digit_cnt, guess_cnt, win
  function automatic logic [23:0] pack(input logic qa, input logic sh, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [3:0] kb,
                                       input logic [2:0] dc, input logic [7:0] gc,
                                       input logic w);
    return {qa, sh, ra, rb, kb, dc, gc, w};
  endfunction

  task automatic expect_s(input string name, input logic qa, input logic sh,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [3:0] kb,
                          input logic [2:0] dc, input logic [7:0] gc, input logic w);
    exp_t e;
    e.name = name;
    e.v    = pack(qa, sh, ra, rb, kb, dc, gc, w);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; drives one key for one cycle and returns at the next negedge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'd15);
  endtask

  // Monitor: compares queued snapshots against the DUT just after each falling edge.
  initial begin
    exp_t e;
    logic [23:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = pack(qa_state, show, r_a, r_b, keypadBuf, digit_cnt, guess_cnt, win);
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s got qa=%b show=%b ra=%0d rb=%0d kb=%0d dc=%0d gc=%0d win=%b exp qa=%b show=%b ra=%0d rb=%0d kb=%0d dc=%0d gc=%0d win=%b",
                   e.name, act[23], act[22], act[21:19], act[18:16], act[15:12], act[11:9],
                   act[8:1], act[0], e.v[23], e.v[22], e.v[21:19], e.v[18:16], e.v[15:12],
                   e.v[11:9], e.v[8:1], e.v[0]);
        end
      end
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #400000;
    if (!stim_done) begin
      $display("FAIL watchdog got timeout exp completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
    end
  end

  // Directed stimulus.
  initial begin
    idle(2);
    rst = 1'b0;
    expect_s("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    press(4'd11);
    expect_s("key11_ignored", 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted while comparing
    enter4(1, 2, 3, 4);
    expect_s("secret_entered", 0, 0, 0, 0, 4, 0, 0, 0);
    enter4(1, 2, 4, 3);
    expect_s("cmp_started", 0, 0, 0, 0, 3, 4, 0, 0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    expect_s("reset_mid_cmp", 1, 0, 0, 0, 0, 0, 0, 0);

    // 1234 vs 1243 -> 2A2B after four edges
    enter4(1, 2, 3, 4);
    enter4(1, 2, 4, 3);
    idle(3);
    expect_s("score_not_before_n4", 0, 0, 0, 0, 3, 4, 0, 0);
    idle(1);
    expect_s("score_2a2b", 0, 1, 2, 2, 3, 0, 1, 0);

    // Duplicate digit, short ENTER, CLEAR
    press(5);
    expect_s("first_digit_clears_show", 0, 0, 2, 2, 5, 1, 1, 0);
    press(5);
    expect_s("dup_rejected", 0, 0, 2, 2, 5, 1, 1, 0);
    press(4'd15);
    idle(5);
    expect_s("short_enter_ignored", 0, 0, 2, 2, 5, 1, 1, 0);
    press(4'd12);
    expect_s("clear", 0, 0, 2, 2, 5, 0, 1, 0);

    // Further scoring patterns
    enter4(5, 6, 7, 8);
    idle(4);
    expect_s("score_0a0b", 0, 1, 0, 0, 8, 0, 2, 0);
    enter4(4, 3, 2, 1);
    idle(4);
    expect_s("score_0a4b", 0, 1, 0, 4, 1, 0, 3, 0);
    enter4(2, 1, 3, 5);
    idle(4);
    expect_s("score_1a2b", 0, 1, 1, 2, 5, 0, 4, 0);
    press(9);
    expect_s("digit_hides_score", 0, 0, 1, 2, 9, 1, 4, 0);
    press(4'd12);

    // Winning guess, key dropped during compare, S_WIN behaviour, KEY_SET
    enter4(1, 2, 3, 4);
    press(7);
    idle(3);
    expect_s("score_4a_win", 0, 1, 4, 0, 4, 0, 5, 1);
    press(7);
    expect_s("win_ignores_key", 0, 1, 4, 0, 4, 0, 5, 1);
    press(4'd10);
    expect_s("key_set_restart", 1, 0, 0, 0, 4, 0, 0, 0);

    // guess_cnt saturation
    enter4(1, 2, 3, 4);
    for (int g = 1; g <= 256; g++) begin
      enter4(5, 6, 7, 8);
      idle(4);
      if (g == 255) expect_s("gc_255", 0, 1, 0, 0, 8, 0, 255, 0);
    end
    expect_s("gc_saturated", 0, 1, 0, 0, 8, 0, 255, 0);

    idle(2);
    stim_done = 1'b1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
